dmem_responder: RTL and testbench

Data-memory responder for the CPU's load/store path. It accepts one word-wide request at a time over a valid/ready handshake, waits a fixed, programmable access latency, then returns read data or a write acknowledgement over a valid/ready response channel. It sits between the CPU data path (initiator) and the on-chip data storage. It replaces the single-cycle combinational memory with a multi-cycle, back-pressurable slave.

---
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed access latency, back-pressurable response.
// Define DMEM_RESP_CHECK_EN to enable alignment/range checking and resp_err reporting.
module dmem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             write_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    word_idx;
    logic             access_err;

    assign word_idx = addr_q[AW+1:2];

`ifdef DMEM_RESP_CHECK_EN
    assign access_err = (addr_q[1:0] != 2'b00) || (|addr_q[WIDTH-1:AW+2]);
`else
    // Without checking, byte offset and upper address bits are simply ignored (index wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q[1:0], addr_q[WIDTH-1:AW+2]};
    assign access_err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            cnt        <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Store commits on the same edge the response becomes valid.
                        if (write_q && !access_err) begin
                            mem[word_idx] <= wdata_q;
                        end
                        resp_rdata <= (write_q || access_err) ? '0 : mem[word_idx];
                        resp_err   <= access_err;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed test-plan cases plus randomized traffic
// checked every cycle against a transaction-level model of the responder.
module tb_dmem_responder;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs as seen by the DUT at the most recent rising edge.
    logic             s_rst = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_write = 1'b0;
    logic [WIDTH-1:0] s_addr = '0;
    logic [WIDTH-1:0] s_wdata = '0;
    logic             s_resp_ready = 1'b0;

    always @(posedge clk) begin
        s_rst        <= rst;
        s_valid      <= req_valid;
        s_write      <= req_write;
        s_addr       <= req_addr;
        s_wdata      <= req_wdata;
        s_resp_ready <= resp_ready;
    end

    // Transaction-level model: expected outputs after each rising edge.
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic             m_ready = 1'b0;
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_rdata = '0;
    logic             m_err = 1'b0;
    logic             m_busy = 1'b0;
    logic             m_wr = 1'b0;
    logic [WIDTH-1:0] m_addr = '0;
    logic [WIDTH-1:0] m_wdata = '0;
    int               m_due = 0;
    int               cyc = 0;
    bit               model_live = 1'b0;

    function automatic logic model_err(input logic [WIDTH-1:0] a);
`ifdef DMEM_RESP_CHECK_EN
        return (a % 4 != 0) || (a >= DEPTH * 4);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int model_idx(input logic [WIDTH-1:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic model_step();
        logic e;
        cyc++;
        if (!s_rst) begin
            model_live = 1'b1;
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_rdata = '0;
            m_err   = 1'b0;
            m_busy  = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (m_valid) begin
            if (s_resp_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end else if (m_busy) begin
            if (cyc == m_due) begin
                e = model_err(m_addr);
                if (m_wr) begin
                    if (!e) m_mem[model_idx(m_addr)] = m_wdata;
                    m_rdata = '0;
                end else begin
                    m_rdata = e ? '0 : m_mem[model_idx(m_addr)];
                end
                m_err   = e;
                m_valid = 1'b1;
                m_busy  = 1'b0;
            end
        end else begin
            if (s_valid && m_ready) begin
                m_wr    = s_write;
                m_addr  = s_addr;
                m_wdata = s_wdata;
                m_busy  = 1'b1;
                m_due   = cyc + LATENCY;
                m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            model_step();
            if (model_live) begin
                check_output("req_ready", 32'(req_ready), 32'(m_ready));
                check_output("resp_valid", 32'(resp_valid), 32'(m_valid));
                if (m_valid || !s_rst) begin
                    check_output("resp_rdata", resp_rdata, m_rdata);
                    check_output("resp_err", 32'(resp_err), 32'(m_err));
                end
            end
        end
    end

    // One full request/response; hold = number of valid cycles before resp_ready rises (0 = ready early).
    task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input int hold, output logic [31:0] rdata, output logic err);
        int waited;
        int lat;
        rdata      = '0;
        err        = 1'b0;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        waited     = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            check_output("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Noise on the request port while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 0;
        @(negedge clk);
        while (resp_valid !== 1'b1 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        check_output("latency", lat, LATENCY);
        if (resp_valid !== 1'b1) begin
            req_valid  = 1'b0;
            resp_ready = 1'b0;
            return;
        end
        rdata = resp_rdata;
        err   = resp_err;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            check_output("hold_valid", 32'(resp_valid), 32'd1);
            check_output("hold_rdata", resp_rdata, rdata);
            check_output("hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin : stimulus
        logic [31:0] rd;
        logic        er;
        int          r;
        int          waited;
        logic [31:0] a;

        rst        = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_output("ready_in_reset_cycle", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_output("ready_after_release", 32'(req_ready), 32'd1);
        check_output("valid_after_release", 32'(resp_valid), 32'd0);
        check_output("rdata_after_release", resp_rdata, 32'd0);

        apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check_output("store_err", 32'(er), 32'd0);
        apply_stimulus(1'b0, 32'h10, 32'h0, 0, rd, er);
        check_output("load_rdata", rd, 32'hDEADBEEF);
        check_output("load_err", 32'(er), 32'd0);

        apply_stimulus(1'b1, 32'h0, 32'hCAFEF00D, 0, rd, er);
        apply_stimulus(1'b0, 32'h0, 32'h0, 5, rd, er);
        check_output("bp_rdata", rd, 32'hCAFEF00D);
        @(negedge clk);
        check_output("bp_ready_after", 32'(req_ready), 32'd1);

`ifdef DMEM_RESP_CHECK_EN
        apply_stimulus(1'b1, 32'h13, 32'h11111111, 0, rd, er);
        check_output("misaligned_err", 32'(er), 32'd1);
        apply_stimulus(1'b1, 32'h100, 32'h22222222, 0, rd, er);
        check_output("range_err", 32'(er), 32'd1);
        apply_stimulus(1'b0, 32'h10, 32'h0, 0, rd, er);
        check_output("after_err_rdata", rd, 32'hDEADBEEF);
        apply_stimulus(1'b0, 32'h0, 32'h0, 0, rd, er);
        check_output("alias_untouched", rd, 32'hCAFEF00D);
        apply_stimulus(1'b0, 32'h101, 32'h0, 1, rd, er);
        check_output("err_load_rdata", rd, 32'h0);
        check_output("err_load_err", 32'(er), 32'd1);
`else
        apply_stimulus(1'b1, 32'h104, 32'h5A5A5A5A, 0, rd, er);
        check_output("wrap_store_err", 32'(er), 32'd0);
        apply_stimulus(1'b0, 32'h004, 32'h0, 0, rd, er);
        check_output("wrap_load_rdata", rd, 32'h5A5A5A5A);
        check_output("wrap_load_err", 32'(er), 32'd0);
`endif

        // Reset while busy: the store must be aborted.
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234;
        req_valid = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output("midbusy_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        do_reset(2);
        apply_stimulus(1'b0, 32'h20, 32'h0, 0, rd, er);
        check_output("midbusy_rdata", rd, 32'h0);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 2));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            r = $urandom_range(0, 9);
            if (r < 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else a = $urandom;
            apply_stimulus(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), rd, er);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
